scan_chain_ctrl: RTL and testbench

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

---
 rtl/scan_chain_ctrl.sv | 179 +++++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sends one SELECT/address/data/UPDATE frame down a TCK scan chain,
// pacing every TCK edge on the returned RTCK and capturing TDO in the data slots.
module scan_chain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] i_pins,
  input  logic                  rtck,
  input  logic                  tdo,
  output logic                  tck,
  output logic                  tms,
  output logic                  tdi,
  output logic [DATA_WIDTH-1:0] o_pins,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int NBITS = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int PAYW  = ADDR_WIDTH + DATA_WIDTH;
  localparam int SLW   = $clog2(NBITS);
  localparam int DIVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TOW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SLW-1:0]  LAST_SLOT  = SLW'(NBITS - 1);
  localparam logic [SLW-1:0]  DATA_FIRST = SLW'(ADDR_WIDTH + 1);
  localparam logic [SLW-1:0]  DATA_LAST  = SLW'(ADDR_WIDTH + DATA_WIDTH);
  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(CLK_DIV - 1);
  localparam logic [TOW-1:0]  TO_LAST    = TOW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT_FALL, FINISH} state_e;

  state_e                state_q;
  logic                  rtckMeta_q, rtckSync_q, tdoMeta_q, tdoSync_q;
  logic                  tck_q, tms_q, tdi_q, busy_q, done_q, error_q;
  logic [DATA_WIDTH-1:0] oPins_q, capture_q;
  logic [PAYW-1:0]       payload_q;
  logic [SLW-1:0]        slot_q;
  logic [DIVW-1:0]       divCnt_q;
  logic [TOW-1:0]        toCnt_q;

  logic [DATA_WIDTH-1:0] captureShift;
  logic [SLW-1:0]        nextSlot;
  logic                  inDataSlot;

  // New samples enter at the MSB so the first data slot ends up in bit 0.
  assign captureShift = DATA_WIDTH'({tdoSync_q, capture_q} >> 1);
  assign nextSlot     = slot_q + 1'b1;
  assign inDataSlot   = (slot_q >= DATA_FIRST) && (slot_q <= DATA_LAST);

  assign tck    = tck_q;
  assign tms    = tms_q;
  assign tdi    = tdi_q;
  assign o_pins = oPins_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rtckMeta_q <= 1'b0;
      rtckSync_q <= 1'b0;
      tdoMeta_q  <= 1'b0;
      tdoSync_q  <= 1'b0;
    end else begin
      rtckMeta_q <= rtck;
      rtckSync_q <= rtckMeta_q;
      tdoMeta_q  <= tdo;
      tdoSync_q  <= tdoMeta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tck_q     <= 1'b0;
      tms_q     <= 1'b0;
      tdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      oPins_q   <= '0;
      capture_q <= '0;
      payload_q <= '0;
      slot_q    <= '0;
      divCnt_q  <= '0;
      toCnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            payload_q <= {i_pins, addr};
            error_q   <= 1'b0;
            busy_q    <= 1'b1;
            slot_q    <= '0;
            divCnt_q  <= '0;
            tms_q     <= 1'b1;
            tdi_q     <= 1'b0;
            state_q   <= LOW;
          end
        end
        LOW: begin
          if (divCnt_q == DIV_LAST) begin
            tck_q    <= 1'b1;
            divCnt_q <= '0;
            toCnt_q  <= '0;
            state_q  <= HIGH;
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end
        HIGH: begin
          if (divCnt_q != DIV_LAST) divCnt_q <= divCnt_q + 1'b1;
          if (rtckSync_q && (divCnt_q == DIV_LAST)) begin
            if (inDataSlot) capture_q <= captureShift;
            tck_q   <= 1'b0;
            toCnt_q <= '0;
            state_q <= WAIT_FALL;
          end else if (toCnt_q == TO_LAST) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            tck_q   <= 1'b0;
            tms_q   <= 1'b0;
            tdi_q   <= 1'b0;
            state_q <= FINISH;
          end else begin
            toCnt_q <= toCnt_q + 1'b1;
          end
        end
        WAIT_FALL: begin
          if (!rtckSync_q) begin
            if (slot_q == LAST_SLOT) begin
              oPins_q <= capture_q;
              done_q  <= 1'b1;
              tms_q   <= 1'b0;
              tdi_q   <= 1'b0;
              state_q <= FINISH;
            end else begin
              // Marker/data for the next slot are set up here, on LOW entry only.
              slot_q   <= nextSlot;
              divCnt_q <= '0;
              state_q  <= LOW;
              if (nextSlot == LAST_SLOT) begin
                tms_q <= 1'b1;
                tdi_q <= 1'b0;
              end else begin
                tms_q     <= 1'b0;
                tdi_q     <= payload_q[0];
                payload_q <= payload_q >> 1;
              end
            end
          end else if (toCnt_q == TO_LAST) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            tck_q   <= 1'b0;
            tms_q   <= 1'b0;
            tdi_q   <= 1'b0;
            state_q <= FINISH;
          end else begin
            toCnt_q <= toCnt_q + 1'b1;
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: loops TCK/TDI back (optionally delayed) and checks every frame
// against a slot-level model of what the chain must see and return.
module tb_scan_chain_ctrl;

  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int CLK_DIV = 2;
  localparam int TIMEOUT = 15;
  localparam int NBITS   = AW + DW + 2;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] addr;
  logic [DW-1:0] iPins;
  logic          rtck, tdo;
  logic          tck, tms, tdi, busy, done, error;
  logic [DW-1:0] oPins;

  // Chain emulation: rtck follows tck after an optional delay, or sticks low.
  logic [15:0] tckHist = '0;
  logic [3:0]  delayIdx = '0;
  logic        useDelay = 1'b0;
  logic        stuckLow = 1'b0;

  int numChecks = 0;
  int numFails  = 0;

  // Model state and monitor bookkeeping.
  logic [NBITS-1:0] expTdiVec, expTmsVec, seenTdi, seenTms;
  logic [DW-1:0]    expPins = '0;
  int  curDelay = 0;
  int  pulseCnt = 0, doneCnt = 0, lowLen = 0, highLen = 0;
  int  cycle = 0, firstRise = 0, doneCycle = 0;
  bit  phaseCheck = 1'b1;
  logic tckPrev = 1'b0, donePrev = 1'b0;

  scan_chain_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .i_pins(iPins),
    .rtck(rtck), .tdo(tdo), .tck(tck), .tms(tms), .tdi(tdi),
    .o_pins(oPins), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tckHist <= {tckHist[14:0], tck};

  assign rtck = stuckLow ? 1'b0 : (useDelay ? tckHist[delayIdx] : tck);
  assign tdo  = tdi;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  function automatic logic bitAt(input logic [NBITS-1:0] v, input int p);
    logic [NBITS-1:0] t;
    t = v >> p;
    return t[0];
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Per-cycle compare process: slot contents on every TCK rise, phase lengths,
  // idle TCK level and done pulse width.
  always @(negedge clk) begin
    if (tck && !tckPrev) begin
      if (pulseCnt == 0) firstRise = cycle;
      if (pulseCnt < NBITS) begin
        checkOutput("slot_tms", 32'(tms), 32'(bitAt(expTmsVec, pulseCnt)));
        checkOutput("slot_tdi", 32'(tdi), 32'(bitAt(expTdiVec, pulseCnt)));
        seenTms = seenTms | (NBITS'(tms) << pulseCnt);
        seenTdi = seenTdi | (NBITS'(tdi) << pulseCnt);
      end
      if (phaseCheck)
        checkOutput("low_phase", 32'(lowLen),
                    32'((pulseCnt == 0) ? CLK_DIV : curDelay + 3 + CLK_DIV));
      lowLen = 0;
      pulseCnt++;
    end
    if (!tck && tckPrev) begin
      if (phaseCheck && !error)
        checkOutput("high_phase", 32'(highLen), 32'(maxInt(curDelay + 3, CLK_DIV)));
      highLen = 0;
    end
    if (tck) highLen++;
    else if (busy) lowLen++;
    if (busy === 1'b0) checkOutput("idle_tck_low", 32'(tck), 32'd0);
    if (done === 1'b1) begin
      doneCnt++;
      doneCycle = cycle;
      checkOutput("done_one_cycle", 32'(donePrev), 32'd0);
    end
    tckPrev  = tck;
    donePrev = done;
    cycle++;
  end

  task automatic setupFrame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int dly, input bit stuck0);
    curDelay   = dly;
    stuckLow   = stuck0;
    useDelay   = (dly > 0);
    delayIdx   = (dly > 0) ? 4'(dly - 1) : 4'd0;
    expTdiVec  = {1'b0, d, a, 1'b0};
    expTmsVec  = (NBITS'(1) << (NBITS - 1)) | NBITS'(1);
    pulseCnt   = 0;
    doneCnt    = 0;
    lowLen     = 0;
    highLen    = 0;
    seenTms    = '0;
    seenTdi    = '0;
    phaseCheck = 1'b1;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr  = a;
    iPins = d;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("error_cleared_on_start", 32'(error), 32'd0);
  endtask

  task automatic runFrame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int dly, input bit stuck0, input bit extraStarts);
    setupFrame(a, d, dly, stuck0);
    applyStimulus(a, d);
    for (int c = 0; c < 1500 && doneCnt == 0; c++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (extraStarts && (c == 30 || c == 90)) begin
        start = 1'b1;
        addr  = ~a;
        iPins = ~d;
      end
    end
    start = 1'b0;
    if (doneCnt == 0) begin
      checkOutput("done_within_budget", 32'd0, 32'd1);
      return;
    end
    checkOutput("busy_during_done", 32'(busy), 32'd1);
    checkOutput("tck_at_done", 32'(tck), 32'd0);
    checkOutput("error_at_done", 32'(error), 32'(stuck0));
    if (stuck0) begin
      checkOutput("tms_at_timeout", 32'(tms), 32'd0);
      checkOutput("timeout_latency", 32'(doneCycle - firstRise), 32'(TIMEOUT));
      checkOutput("timeout_pulses", 32'(pulseCnt), 32'd1);
      checkOutput("opins_kept_on_timeout", 32'(oPins), 32'(expPins));
    end else begin
      expPins = d;
      checkOutput("frame_pulses", 32'(pulseCnt), 32'(NBITS));
      checkOutput("opins_loopback", 32'(oPins), 32'(expPins));
    end
    if (extraStarts) start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("done_cleared", 32'(done), 32'd0);
    repeat (25) begin
      @(negedge clk); #1;
    end
    checkOutput("single_done", 32'(doneCnt), 32'd1);
    checkOutput("no_second_frame", 32'(pulseCnt), 32'(stuck0 ? 1 : NBITS));
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tck"}, 32'(tck), 32'd0);
    checkOutput({tag, "_tms"}, 32'(tms), 32'd0);
    checkOutput({tag, "_tdi"}, 32'(tdi), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_opins"}, 32'(oPins), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    bit            reached;
    reset = 1'b1;
    start = 1'b1;
    addr  = 8'h3C;
    iPins = 8'hC3;
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("reset_with_start");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk); #1;
    checkResetOutputs("after_reset_release");

    $display("[TB] loopback frame addr=0x01 data=0xA5");
    runFrame(8'h01, 8'hA5, 0, 1'b0, 1'b0);
    checkOutput("pinned_tms_pattern", 32'(seenTms), 32'h20001);
    checkOutput("pinned_tdi_pattern", 32'(seenTdi), 32'h14A02);
    checkOutput("pinned_opins", 32'(oPins), 32'hA5);
    checkOutput("pinned_error", 32'(error), 32'd0);

    $display("[TB] rtck stuck low");
    runFrame(8'h5A, 8'h0F, 0, 1'b1, 1'b0);
    checkOutput("error_held_after_timeout", 32'(error), 32'd1);

    $display("[TB] rtck delayed 6 cycles");
    runFrame(8'hC7, 8'h39, 6, 1'b0, 1'b0);

    $display("[TB] extra starts mid-frame and in finish");
    runFrame(8'h80, 8'h7E, 0, 1'b0, 1'b1);

    $display("[TB] reset in address slot 4");
    ra = 8'($urandom);
    rd = 8'($urandom);
    setupFrame(ra, rd, 0, 1'b0);
    applyStimulus(ra, rd);
    reached = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      @(negedge clk); #1;
      reached = (pulseCnt >= 5);
    end
    checkOutput("reached_slot4", 32'(reached), 32'd1);
    phaseCheck = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    expPins = '0;
    checkResetOutputs("mid_frame_reset");
    repeat (20) @(negedge clk);
    #1;
    runFrame(8'h96, 8'h69, 0, 1'b0, 1'b0);

    $display("[TB] randomized frames");
    for (int n = 0; n < 6; n++) begin
      ra = 8'($urandom);
      rd = 8'($urandom);
      runFrame(ra, rd, int'($urandom_range(0, 6)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
